pipe_reg_chain: RTL and testbench

Parametrised elastic register pipeline: `Depth` stages of `Bits`-wide data registers, each with its own valid flag, joined by a valid/ready handshake. Bubbles collapse and backpressure propagates stage by stage. Used wherever the datapath needs retiming or a fixed minimum delay that must still honour downstream stalls, for example between MAC array and activation/pooling stages. Supports synchronous flush and reports occupancy.

---
 rtl/pipe_reg_chain_pkg.sv | 26 ++
 rtl/pipe_stage.sv | 51 +++++
 rtl/pipe_reg_chain.sv | 95 +++++++++
 tb/tb_pipe_reg_chain.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_reg_chain_pkg.sv
// Shared types for the elastic register pipeline.
// Provides the occupancy-counter update encoding and its decode helper.
package pipe_reg_chain_pkg;

    typedef enum logic [1:0] {
        CntHold = 2'd0,
        CntInc  = 2'd1,
        CntDec  = 2'd2
    } cnt_op_e;

    // Accept-and-emit in the same cycle leaves occupancy unchanged.
    function automatic cnt_op_e cnt_op(
        input logic in_hs,
        input logic out_hs
    );
        cnt_op_e op;
        op = CntHold;
        unique case ({in_hs, out_hs})
            2'b10:   op = CntInc;
            2'b01:   op = CntDec;
            default: op = CntHold;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/pipe_stage.sv
// One elastic pipeline stage: a valid flag plus an enabled data register.
// Ports: clk/rst/flush, upstream valid+data, downstream ready; valid, data, ready out.
module pipe_stage
    import pipe_reg_chain_pkg::*;
#(
    parameter int Bits = 8
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            flush_i,
    input  logic            up_valid_i,
    input  logic [Bits-1:0] up_data_i,
    input  logic            dn_ready_i,
    output logic            valid_o,
    output logic [Bits-1:0] data_o,
    output logic            ready_o
);

    logic            valid_q, valid_d;
    logic [Bits-1:0] data_q, data_d;

    // An empty stage always accepts; a full one only if it drains.
    assign ready_o = ~valid_q | dn_ready_i;

    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        if (flush_i) begin
            valid_d = 1'b0;
        end else if (ready_o) begin
            valid_d = up_valid_i;
            if (up_valid_i) begin
                data_d = up_data_i;
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    assign valid_o = valid_q;
    assign data_o  = data_q;

endmodule

// File: rtl/pipe_reg_chain.sv
// Elastic register pipeline of Depth stages with flush and occupancy count.
// Ports: in valid/ready/data, out valid/ready/data, flush_i, count_o.
module pipe_reg_chain
    import pipe_reg_chain_pkg::*;
#(
    parameter int Bits  = 8,
    parameter int Depth = 2
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       flush_i,
    input  logic                       in_valid_i,
    output logic                       in_ready_o,
    input  logic [Bits-1:0]            in_data_i,
    output logic                       out_valid_o,
    input  logic                       out_ready_i,
    output logic [Bits-1:0]            out_data_o,
    output logic [$clog2(Depth+1)-1:0] count_o
);

    localparam int CountBits = $clog2(Depth + 1);

    for (genvar k = 0; k < Depth; k++) begin : g_st
        logic            up_v;
        logic [Bits-1:0] up_d;
        logic            dn_r;
        logic            vld;
        logic [Bits-1:0] dat;
        logic            rdy;

        if (k == 0) begin : g_head
            assign up_v = in_valid_i;
            assign up_d = in_data_i;
        end else begin : g_mid
            assign up_v = g_st[k-1].vld;
            assign up_d = g_st[k-1].dat;
        end

        if (k == Depth - 1) begin : g_tail
            assign dn_r = out_ready_i;
        end else begin : g_next
            assign dn_r = g_st[k+1].rdy;
        end

        pipe_stage #(
            .Bits(Bits)
        ) u_stage (
            .clk_i      (clk_i),
            .rst_i      (rst_i),
            .flush_i    (flush_i),
            .up_valid_i (up_v),
            .up_data_i  (up_d),
            .dn_ready_i (dn_r),
            .valid_o    (vld),
            .data_o     (dat),
            .ready_o    (rdy)
        );
    end

    // Hold off the producer during reset and on the flush cycle.
    assign in_ready_o  = g_st[0].rdy & ~flush_i & ~rst_i;
    assign out_valid_o = g_st[Depth-1].vld & ~flush_i;
    assign out_data_o  = g_st[Depth-1].dat;

    logic                 in_hs;
    logic                 out_hs;
    logic [CountBits-1:0] count_q, count_d;

    assign in_hs  = in_valid_i & in_ready_o;
    assign out_hs = out_valid_o & out_ready_i;

    always_comb begin
        count_d = count_q;
        if (flush_i) begin
            count_d = '0;
        end else begin
            unique case (cnt_op(in_hs, out_hs))
                CntInc:  count_d = count_q + CountBits'(1);
                CntDec:  count_d = count_q - CountBits'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;

endmodule

// File: tb/tb_pipe_reg_chain.sv
// Directed and randomized checks of pipe_reg_chain with Depth=3, Bits=8.
// Expected values are hand-derived or come from a reference queue.
module tb_pipe_reg_chain;

    localparam int Bits  = 8;
    localparam int Depth = 3;
    localparam int CB    = $clog2(Depth + 1);

    logic            clk_i = 1'b0;
    logic            rst_i = 1'b1;
    logic            flush_i = 1'b0;
    logic            in_valid_i = 1'b0;
    logic            in_ready_o;
    logic [Bits-1:0] in_data_i = '0;
    logic            out_valid_o;
    logic            out_ready_i = 1'b0;
    logic [Bits-1:0] out_data_o;
    logic [CB-1:0]   count_o;

    int n_vec = 0;
    int n_bad = 0;

    pipe_reg_chain #(
        .Bits  (Bits),
        .Depth (Depth)
    ) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .flush_i     (flush_i),
        .in_valid_i  (in_valid_i),
        .in_ready_o  (in_ready_o),
        .in_data_i   (in_data_i),
        .out_valid_o (out_valid_o),
        .out_ready_i (out_ready_i),
        .out_data_o  (out_data_o),
        .count_o     (count_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, want %0h", tag, got, exp);
        end
    endtask

    // Inputs change 1 time unit after the edge; checks follow 1 unit later.
    task automatic drive(input logic v, input logic [Bits-1:0] d,
                         input logic r);
        in_valid_i  = v;
        in_data_i   = d;
        out_ready_i = r;
        #1;
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    logic [Bits-1:0] q[$];
    logic            exp_rdy;
    logic            ok;

    initial begin
        // Reset state
        #2;
        chk("rst_out_valid", 32'(out_valid_o), 0);
        chk("rst_out_data", 32'(out_data_o), 0);
        chk("rst_in_ready", 32'(in_ready_o), 0);
        chk("rst_count", 32'(count_o), 0);
        #10 rst_i = 1'b0;
        #1;
        chk("post_rst_in_ready", 32'(in_ready_o), 1);
        tick();

        // Back-to-back stream, output always ready
        drive(1'b1, 8'h11, 1'b1);
        chk("s1_in_ready", 32'(in_ready_o), 1);
        chk("s1_empty_valid", 32'(out_valid_o), 0);
        tick();
        drive(1'b1, 8'h22, 1'b1);
        chk("s1_count1", 32'(count_o), 1);
        tick();
        drive(1'b1, 8'h33, 1'b1);
        chk("s1_count2", 32'(count_o), 2);
        chk("s1_not_yet", 32'(out_valid_o), 0);
        tick();
        drive(1'b0, 8'h00, 1'b1);
        chk("s1_lat_valid", 32'(out_valid_o), 1);
        chk("s1_data11", 32'(out_data_o), 32'h11);
        chk("s1_count_peak", 32'(count_o), 3);
        tick();
        chk("s1_data22", 32'(out_data_o), 32'h22);
        chk("s1_count_dn", 32'(count_o), 2);
        tick();
        chk("s1_data33", 32'(out_data_o), 32'h33);
        tick();
        chk("s1_drained_v", 32'(out_valid_o), 0);
        chk("s1_drained_c", 32'(count_o), 0);

        // Fill while stalled, then release
        drive(1'b1, 8'hA1, 1'b0);
        tick();
        drive(1'b1, 8'hA2, 1'b0);
        tick();
        drive(1'b1, 8'hA3, 1'b0);
        chk("s2_rdy_third", 32'(in_ready_o), 1);
        tick();
        drive(1'b1, 8'hA4, 1'b0);
        chk("s2_full_rdy", 32'(in_ready_o), 0);
        chk("s2_full_cnt", 32'(count_o), 3);
        chk("s2_head", 32'(out_data_o), 32'hA1);
        tick();
        chk("s2_hold_data", 32'(out_data_o), 32'hA1);
        chk("s2_hold_valid", 32'(out_valid_o), 1);
        drive(1'b1, 8'hA4, 1'b1);
        chk("s2_pass_rdy", 32'(in_ready_o), 1);
        tick();
        drive(1'b0, 8'h00, 1'b1);
        chk("s2_swap_cnt", 32'(count_o), 3);
        chk("s2_next", 32'(out_data_o), 32'hA2);
        tick();
        chk("s2_a3", 32'(out_data_o), 32'hA3);
        tick();
        chk("s2_a4", 32'(out_data_o), 32'hA4);
        tick();
        chk("s2_empty", 32'(count_o), 0);

        // Bubble collapse behind a stalled output
        drive(1'b1, 8'hB1, 1'b0);
        tick();
        drive(1'b0, 8'h00, 1'b0);
        tick();
        tick();
        drive(1'b1, 8'hB2, 1'b0);
        tick();
        drive(1'b0, 8'h00, 1'b0);
        chk("s3_cnt2", 32'(count_o), 2);
        chk("s3_head", 32'(out_data_o), 32'hB1);
        tick();
        chk("s3_cnt_hold", 32'(count_o), 2);
        chk("s3_rdy", 32'(in_ready_o), 1);
        drive(1'b0, 8'h00, 1'b1);
        chk("s3_first", 32'(out_data_o), 32'hB1);
        tick();
        chk("s3_second_v", 32'(out_valid_o), 1);
        chk("s3_second", 32'(out_data_o), 32'hB2);
        tick();
        chk("s3_empty", 32'(out_valid_o), 0);

        // Flush with two items in flight
        drive(1'b1, 8'hC1, 1'b0);
        tick();
        drive(1'b1, 8'hC2, 1'b0);
        tick();
        chk("s4_pre_cnt", 32'(count_o), 2);
        flush_i = 1'b1;
        drive(1'b1, 8'hC3, 1'b1);
        chk("s4_fl_valid", 32'(out_valid_o), 0);
        chk("s4_fl_rdy", 32'(in_ready_o), 0);
        tick();
        flush_i = 1'b0;
        drive(1'b1, 8'hC4, 1'b1);
        chk("s4_post_cnt", 32'(count_o), 0);
        chk("s4_post_valid", 32'(out_valid_o), 0);
        tick();
        drive(1'b0, 8'h00, 1'b1);
        chk("s4_lat1", 32'(out_valid_o), 0);
        tick();
        chk("s4_lat2", 32'(out_valid_o), 0);
        tick();
        chk("s4_lat3_v", 32'(out_valid_o), 1);
        chk("s4_lat3_d", 32'(out_data_o), 32'hC4);
        tick();
        chk("s4_empty", 32'(count_o), 0);

        // Asynchronous reset with the pipe full
        drive(1'b1, 8'hD1, 1'b0);
        tick();
        drive(1'b1, 8'hD2, 1'b0);
        tick();
        drive(1'b1, 8'hD3, 1'b0);
        tick();
        drive(1'b0, 8'h00, 1'b0);
        chk("s5_full", 32'(count_o), 3);
        #1 rst_i = 1'b1;
        #1;
        chk("s5_rst_valid", 32'(out_valid_o), 0);
        chk("s5_rst_data", 32'(out_data_o), 0);
        chk("s5_rst_cnt", 32'(count_o), 0);
        chk("s5_rst_rdy", 32'(in_ready_o), 0);
        tick();
        #2 rst_i = 1'b0;
        tick();
        chk("s5_after_rdy", 32'(in_ready_o), 1);

        // Random stress against a reference queue
        q.delete();
        for (int i = 0; i < 10000; i++) begin
            drive(1'($urandom_range(0, 1)), 8'($urandom),
                  1'($urandom_range(0, 3) != 0));
            exp_rdy = (q.size() < Depth) || out_ready_i;
            chk("st_count", 32'(count_o), 32'(q.size()));
            chk("st_in_ready", 32'(in_ready_o), 32'(exp_rdy));
            if (out_valid_o) begin
                ok = q.size() > 0;
                chk("st_nonempty", 32'(ok), 1);
                if (ok) chk("st_order", 32'(out_data_o), 32'(q[0]));
            end
            if (out_valid_o && out_ready_i && q.size() > 0)
                void'(q.pop_front());
            if (in_valid_i && exp_rdy) q.push_back(in_data_i);
            tick();
        end
        drive(1'b0, 8'h00, 1'b1);
        for (int i = 0; i < Depth + 2; i++) tick();
        chk("st_drain", 32'(count_o), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
